fft2_out_serializer: RTL and testbench
======================================

// Module: fft2_out_serializer
// PURPOSE
//  Downstream stage of the radix-2 butterfly. Accepts one butterfly result
//  (17-bit signed sum and difference, real and imaginary) per handshake.
//  Scales and saturates each component to 16 bits, then serializes the pair
//  onto a single 16-bit complex valid/ready stream: sum first, difference second.
//  Counts saturation events for overflow monitoring.
// PARAMETERS
//  SHIFT    1   right-shift applied before saturation; legal values 0 or 1
//  CNT_W   16   width of the saturation event counter
// PORTS
//  clk        in   1       system clock; all logic on rising edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       butterfly result valid
//  in_ready   out  1       block can accept a result this cycle
//  in_sumr    in   17 s    sum, real
//  in_sumi    in   17 s    sum, imaginary
//  in_subr    in   17 s    difference, real
//  in_subi    in   17 s    difference, imaginary
//  out_valid  out  1       output sample valid
//  out_ready  in   1       consumer accepts output sample
//  out_r      out  16 s    output sample, real
//  out_i      out  16 s    output sample, imaginary
//  out_last   out  1       1 = difference sample (second of pair)
//  sat_clr    in   1       synchronous clear of sat_cnt
//  sat_cnt    out  CNT_W   saturated-component count; sticks at all-ones
// BEHAVIOUR
//  - Reset: FSM=EMPTY; out_valid=0, out_r=0, out_i=0, out_last=0, sat_cnt=0.
//  - Reset mid-pair discards any held data. No output is emitted for it.
//  - FSM states: EMPTY, SUM, SUB. out_valid=1 in SUM and SUB.
//  - in_ready = (state==EMPTY) | (state==SUB & out_ready).
//  - Accept occurs when in_valid & in_ready. On accept, all four components are
//    scaled and saturated into holding regs. The FSM moves to SUM the next cycle.
//  - Latency is 1 cycle from accept to out_valid.
//  - SUM state: out_r/out_i = sum regs, out_last=0.
//    - out_ready=1 -> SUB; otherwise hold.
//  - SUB state: out_r/out_i = sub regs, out_last=1.
//    - out_ready=1 with a new accept -> SUM with the new data.
//    - out_ready=1 with no accept -> EMPTY.
//    - out_ready=0 -> hold.
//  - Output data and out_last are stable while out_valid & !out_ready.
//  - Throughput is one pair per 2 cycles with no bubbles under continuous flow.
//  - Scaling:
//    - Compute y = x >>> SHIFT, arithmetic shift, in 18-bit intermediate.
//    - Saturate y to [-32768, 32767].
//  - sat_cnt behaviour:
//    - Adds the number of components clamped at accept (0..4).
//    - Saturates at 2^CNT_W-1.
//    - sat_clr has priority over a same-cycle increment; result is 0.
// CONFIGURATION
//  FFT2_ROUND_EN defined:
//    - Round-half-up before the shift: y = (x + (SHIFT ? 1 : 0)) >>> SHIFT.
//    - Saturate after rounding.
//  FFT2_ROUND_EN undefined:
//    - Plain truncation (floor) by arithmetic shift. No rounding adder.
//  - Has no effect when SHIFT=0.
// TESTING
//  1. SHIFT=1, ROUND_EN on. Input sum=(3,-3), sub=(65535,-65536).
//     -> (2,-1) last=0, then (32767,-32768) last=1; sat_cnt=1.
//  2. SHIFT=1, ROUND_EN off, same input.
//     -> (1,-2), then (32767,-32768); sat_cnt=0.
//  3. SHIFT=0. sum=(40000,-40000), sub=(5,-5).
//     -> (32767,-32768), then (5,-5); sat_cnt=2.
//  4. Hold out_ready=0 for 5 cycles in SUM.
//     -> out_r/out_i/out_last constant, in_ready=0. Release -> SUB next cycle.
//  5. in_valid=1 and out_ready=1 continuously, 4 pairs.
//     -> out_valid high 8 consecutive cycles. out_last toggles 0,1,0,1...
//     -> in_ready high on every SUB cycle.
//  6. Assert rst in SUB state with sat_cnt=3.
//     -> next cycle out_valid=0, in_ready=1, sat_cnt=0.
//     Then set CNT_W=2 and force 5 saturations -> sat_cnt sticks at 3.
//     Assert sat_clr -> 0.

Source files
------------

// File: rtl/fft2_out_serializer_if.sv
// Stream bundle for fft2_out_serializer: butterfly-result input stream and
// serialized 16-bit complex output stream.
interface fft2_out_serializer_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [16:0] in_sumr;
  logic signed [16:0] in_sumi;
  logic signed [16:0] in_subr;
  logic signed [16:0] in_subi;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_r;
  logic signed [15:0] out_i;
  logic               out_last;

  modport slave (
    input  in_valid, in_sumr, in_sumi, in_subr, in_subi, out_ready,
    output in_ready, out_valid, out_r, out_i, out_last
  );

  modport master (
    output in_valid, in_sumr, in_sumi, in_subr, in_subi, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_last
  );
endinterface

// File: rtl/fft2_out_serializer.sv
// Scales/saturates a radix-2 butterfly result and serializes sum then difference
// onto one complex stream. Optional macro FFT2_ROUND_EN: round-half-up before the shift.
module fft2_out_serializer #(
  parameter int SHIFT = 1,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  fft2_out_serializer_if.slave bus,
  input  logic                 sat_clr,
  output logic [CNT_W-1:0]     sat_cnt
);
  localparam int SW = (CNT_W + 1 > 3) ? CNT_W + 1 : 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {EMPTY, SUM, SUB} state_t;

  state_t             state_q;
  logic signed [15:0] subr_q, subi_q;
  logic signed [15:0] out_r_q, out_i_q;
  logic               out_valid_q, out_last_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               in_ready, accept;
  logic               sr_sat, si_sat, dr_sat, di_sat;
  logic signed [15:0] sumr_d, sumi_d, subr_d, subi_d;
  logic [2:0]         sat_inc;
  logic [SW-1:0]      cnt_sum;

  // Returns {clamped flag, 16-bit result}; 18-bit intermediate covers the rounding carry.
  function automatic logic [16:0] scale_sat(input logic signed [16:0] x);
    logic signed [17:0] y;
    logic signed [15:0] v;
    logic               sat;
    y = {x[16], x};
`ifdef FFT2_ROUND_EN
    y = (y + ((SHIFT != 0) ? 18'sd1 : 18'sd0)) >>> SHIFT;
`else
    y = y >>> SHIFT;
`endif
    v   = y[15:0];
    sat = 1'b0;
    if (y > 18'sd32767) begin
      v   = 16'sh7fff;
      sat = 1'b1;
    end else if (y < -18'sd32768) begin
      v   = 16'sh8000;
      sat = 1'b1;
    end
    return {sat, v};
  endfunction

  always_comb begin
    in_ready         = (state_q == EMPTY) || ((state_q == SUB) && bus.out_ready);
    accept           = bus.in_valid && in_ready;
    {sr_sat, sumr_d} = scale_sat(bus.in_sumr);
    {si_sat, sumi_d} = scale_sat(bus.in_sumi);
    {dr_sat, subr_d} = scale_sat(bus.in_subr);
    {di_sat, subi_d} = scale_sat(bus.in_subi);
    sat_inc          = 3'(sr_sat) + 3'(si_sat) + 3'(dr_sat) + 3'(di_sat);
    cnt_sum          = SW'(cnt_q) + SW'(sat_inc);
    if (sat_clr)
      cnt_d = '0;
    else if (!accept)
      cnt_d = cnt_q;
    else if (cnt_sum > SW'(CNT_MAX))
      cnt_d = CNT_MAX;
    else
      cnt_d = cnt_sum[CNT_W-1:0];
  end

  // Accept stage: scaled sum goes straight to the output regs, difference is parked.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) begin
        state_q     <= SUM;
        out_valid_q <= 1'b1;
        out_last_q  <= 1'b0;
        out_r_q     <= sumr_d;
        out_i_q     <= sumi_d;
        subr_q      <= subr_d;
        subi_q      <= subi_d;
      end else begin
        case (state_q)
          SUM: if (bus.out_ready) begin
            state_q    <= SUB;
            out_last_q <= 1'b1;
            out_r_q    <= subr_q;
            out_i_q    <= subi_q;
          end
          SUB: if (bus.out_ready) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_i     = out_i_q;
  assign sat_cnt       = cnt_q;
endmodule

// File: tb/tb_fft2_out_serializer.sv
// Directed bench for fft2_out_serializer: u0 uses SHIFT=1/CNT_W=16, u1 uses SHIFT=0/CNT_W=2.
module tb_fft2_out_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr0 = 1'b0, clr1 = 1'b0;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  int          nvec = 0, nbad = 0;
  int          exp_cnt;

  fft2_out_serializer_if b0();
  fft2_out_serializer_if b1();

  fft2_out_serializer #(.SHIFT(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave), .sat_clr(clr0), .sat_cnt(cnt0));
  fft2_out_serializer #(.SHIFT(0), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave), .sat_clr(clr1), .sat_cnt(cnt1));

  always #5 clk = ~clk;

  typedef struct {
    int sr, si, dr, di;
    int esr, esi, edr, edi;
    int nsat;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v, input int sr, input int si,
                       input int dr, input int di, input logic ordy);
    if (sel == 0) begin
      b0.in_valid = v; b0.in_sumr = 17'(sr); b0.in_sumi = 17'(si);
      b0.in_subr = 17'(dr); b0.in_subi = 17'(di); b0.out_ready = ordy;
    end else begin
      b1.in_valid = v; b1.in_sumr = 17'(sr); b1.in_sumi = 17'(si);
      b1.in_subr = 17'(dr); b1.in_subi = 17'(di); b1.out_ready = ordy;
    end
  endtask

  task automatic chk_out(input int sel, input string nm, input logic ov, input logic ol,
                         input int er, input int ei);
    logic ov_a, ol_a;
    logic signed [15:0] r_a, i_a;
    if (sel == 0) begin
      ov_a = b0.out_valid; ol_a = b0.out_last; r_a = b0.out_r; i_a = b0.out_i;
    end else begin
      ov_a = b1.out_valid; ol_a = b1.out_last; r_a = b1.out_r; i_a = b1.out_i;
    end
    chk({nm, ".valid"}, ov_a, ov);
    chk({nm, ".last"}, ol_a, ol);
    if (ov) begin
      chk({nm, ".r"}, r_a, er);
      chk({nm, ".i"}, i_a, ei);
    end
  endtask

  initial begin
`ifdef FFT2_ROUND_EN
    tbl[0] = '{3, -3, 65535, -65536,      2, -1, 32767, -32768,  1};
    tbl[1] = '{0, -1, 1, -2,              0, 0, 1, -1,            0};
    tbl[2] = '{65534, -65535, 100, -101,  32767, -32767, 50, -50, 0};
    tbl[3] = '{65535, 65535, -65536, -65536, 32767, 32767, -32768, -32768, 2};
    tbl[4] = '{12345, -12345, 7, -7,      6173, -6172, 4, -3,     0};
`else
    tbl[0] = '{3, -3, 65535, -65536,      1, -2, 32767, -32768,  0};
    tbl[1] = '{0, -1, 1, -2,              0, -1, 0, -1,           0};
    tbl[2] = '{65534, -65535, 100, -101,  32767, -32768, 50, -51, 0};
    tbl[3] = '{65535, 65535, -65536, -65536, 32767, 32767, -32768, -32768, 0};
    tbl[4] = '{12345, -12345, 7, -7,      6172, -6173, 3, -4,     0};
`endif

    drive(0, 0, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    chk_out(0, "rst0", 0, 0, 0, 0);
    chk("rst0.r", b0.out_r, 0);
    chk("rst0.i", b0.out_i, 0);
    chk("rst0.in_ready", b0.in_ready, 1);
    chk("rst0.cnt", cnt0, 0);
    chk_out(1, "rst1", 0, 0, 0, 0);
    chk("rst1.cnt", cnt1, 0);

    // Scaling/saturation table on u0
    exp_cnt = 0;
    for (int n = 0; n < 5; n++) begin
      drive(0, 1, tbl[n].sr, tbl[n].si, tbl[n].dr, tbl[n].di, 1);
      chk($sformatf("v%0d.in_ready", n), b0.in_ready, 1);
      step();
      drive(0, 0, 0, 0, 0, 0, 1);
      exp_cnt += tbl[n].nsat;
      chk_out(0, $sformatf("v%0d.sum", n), 1, 0, tbl[n].esr, tbl[n].esi);
      chk($sformatf("v%0d.cnt", n), cnt0, exp_cnt);
      step();
      chk_out(0, $sformatf("v%0d.sub", n), 1, 1, tbl[n].edr, tbl[n].edi);
      step();
      chk($sformatf("v%0d.empty", n), b0.out_valid, 0);
    end

    // Back-pressure in SUM for 5 cycles
    drive(0, 1, 1000, -1000, 6, -8, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      chk_out(0, $sformatf("hold%0d", c), 1, 0, 500, -500);
      chk($sformatf("hold%0d.in_ready", c), b0.in_ready, 0);
      step();
    end
    chk_out(0, "hold.end", 1, 0, 500, -500);
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    chk_out(0, "release", 1, 1, 3, -4);
    step();
    chk("release.empty", b0.out_valid, 0);
    chk("release.in_ready", b0.in_ready, 1);

    // Continuous flow: 4 pairs back to back
    drive(0, 1, 2, -4, 6, -8, 1);
    for (int c = 0; c < 8; c++) begin
      int k;
      k = c / 2;
      step();
      if ((c % 2) == 0)
        chk_out(0, $sformatf("flow%0d", c), 1, 0, k * 10 + 1, -(k * 10 + 2));
      else
        chk_out(0, $sformatf("flow%0d", c), 1, 1, k * 10 + 3, -(k * 10 + 4));
      chk($sformatf("flow%0d.in_ready", c), b0.in_ready, c % 2);
      if ((c % 2) == 1 && k < 3)
        drive(0, 1, 2 * ((k + 1) * 10 + 1), -2 * ((k + 1) * 10 + 2),
              2 * ((k + 1) * 10 + 3), -2 * ((k + 1) * 10 + 4), 1);
      else
        drive(0, 0, 0, 0, 0, 0, 1);
    end
    step();
    chk("flow.empty", b0.out_valid, 0);

    // SHIFT=0 saturation on u1
    drive(1, 1, 40000, -40000, 5, -5, 1);
    step();
    drive(1, 0, 0, 0, 0, 0, 1);
    chk_out(1, "s0.sum", 1, 0, 32767, -32768);
    chk("s0.cnt", cnt1, 2);
    step();
    chk_out(1, "s0.sub", 1, 1, 5, -5);
    step();

    // Reset while holding in SUB
    drive(1, 1, 1, 2, -40000, 3, 1);
    step();
    drive(1, 0, 0, 0, 0, 0, 1);
    step();
    drive(1, 0, 0, 0, 0, 0, 0);
    chk_out(1, "midrst.sub", 1, 1, -32768, 3);
    chk("midrst.cnt", cnt1, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_out(1, "midrst.after", 0, 0, 0, 0);
    chk("midrst.in_ready", b1.in_ready, 1);
    chk("midrst.cnt0", cnt1, 0);
    drive(1, 0, 0, 0, 0, 0, 1);
    step();
    chk("midrst.noemit", b1.out_valid, 0);

    // Counter sticks at all-ones after 5 saturations
    drive(1, 1, 40000, 1, 2, 3, 1);
    step();
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("stick.cnt1", cnt1, 1);
    repeat (2) step();
    drive(1, 1, 40000, -40000, 40000, -40000, 1);
    step();
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("stick.cnt5", cnt1, 3);
    repeat (2) step();
    chk("stick.hold", cnt1, 3);
    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    chk("clr.cnt", cnt1, 0);

    // Clear beats a same-cycle increment
    drive(1, 1, 40000, 0, 0, 0, 1);
    clr1 = 1'b1;
    step();
    clr1 = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("clrpri.cnt", cnt1, 0);
    chk_out(1, "clrpri.sum", 1, 0, 32767, 0);
    repeat (2) step();
    chk("clrpri.after", cnt1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
